// File: rtl/wb_master_pkg.sv
// Shared types and bus widths for the Wishbone command master.
// No logic; imported by the master and its sub-blocks.
// No backpressure; types only.
package wb_master_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Wait-state counter for one Wishbone cycle; expired flags the last allowed STB cycle.
// Latency: expired is combinational from the registered count.
// No backpressure; clr and en are driven by the master FSM.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt;

            // Count stops at LIMIT so the equality compare can never be skipped.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt <= '0;
                end else if (en && !expired) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expired = (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Latency: command handshake at edge N raises CYC/STB in cycle N+1; response one cycle after ACK or expiry.
// Backpressure: cmd_ready only in IDLE; a held response blocks new commands until rsp_ready.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                busy,
    output logic [CNT_W-1:0]    timeout_cnt
);

    state_t              state, state_nxt;
    logic                cyc_nxt, stb_nxt, we_nxt;
    logic [WB_SEL_W-1:0] sel_nxt;
    logic [WB_ADR_W-1:0] adr_nxt;
    logic [WB_DAT_W-1:0] dat_nxt;
    logic                rsp_valid_nxt, rsp_err_nxt;
    logic [WB_DAT_W-1:0] rsp_dat_nxt;
    logic [CNT_W-1:0]    tcnt_nxt;
    logic                tmr_clr, tmr_en, tmr_expired;

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        cyc_nxt       = wbm_cyc_o;
        stb_nxt       = wbm_stb_o;
        we_nxt        = wbm_we_o;
        sel_nxt       = wbm_sel_o;
        adr_nxt       = wbm_adr_o;
        dat_nxt       = wbm_dat_o;
        rsp_valid_nxt = rsp_valid;
        rsp_dat_nxt   = rsp_dat;
        rsp_err_nxt   = rsp_err;
        tcnt_nxt      = timeout_cnt;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_nxt    = cmd_we;
                    sel_nxt   = cmd_sel;
                    adr_nxt   = cmd_adr;
                    dat_nxt   = cmd_dat;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // ACK takes priority over a coincident expiry.
                if (wbm_ack_i) begin
                    rsp_dat_nxt   = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    state_nxt     = RESP;
                end else if (tmr_expired) begin
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    tcnt_nxt      = (&timeout_cnt) ? timeout_cnt : timeout_cnt + CNT_W'(1);
                    state_nxt     = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            timeout_cnt <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            wbm_cyc_o   <= cyc_nxt;
            wbm_stb_o   <= stb_nxt;
            wbm_we_o    <= we_nxt;
            wbm_sel_o   <= sel_nxt;
            wbm_adr_o   <= adr_nxt;
            wbm_dat_o   <= dat_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_dat     <= rsp_dat_nxt;
            rsp_err     <= rsp_err_nxt;
            timeout_cnt <= tcnt_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master with a transaction-level reference model.
module tb_wb_cmd_master;

    localparam int TO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int errors = 0;
    int checks = 0;
    int exp_tcnt = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_cmd_master #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    // wait_n: ACK on STB cycle wait_n+1; negative means the slave never ACKs.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int wait_n, input logic [31:0] rd,
                           input int hold);
        int          k;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_dat;
        if (wait_n >= 0 && wait_n < TO) begin
            exp_stb = wait_n + 1;
            exp_err = 1'b0;
            exp_dat = we ? 32'h0 : rd;
        end else begin
            exp_stb = TO;
            exp_err = 1'b1;
            exp_dat = 32'h0;
            if (exp_tcnt < 255) exp_tcnt++;
        end

        chk_eq("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        k = 0;
        while (wbm_stb_o === 1'b1 && k < TO + 8) begin
            chk_eq("bus_cyc", {31'b0, wbm_cyc_o}, 32'd1);
            chk_eq("bus_adr", wbm_adr_o, adr);
            chk_eq("bus_dat", wbm_dat_o, dat);
            chk_eq("bus_sel", {28'b0, wbm_sel_o}, {28'b0, sel});
            chk_eq("bus_we", {31'b0, wbm_we_o}, {31'b0, we});
            chk_eq("bus_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            wbm_ack_i = (k == wait_n);
            wbm_dat_i = (k == wait_n) ? rd : $urandom;
            tick();
            k++;
        end
        wbm_ack_i = 1'b0;

        chk_eq("stb_cycles", k, exp_stb);
        chk_eq("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk_eq("rsp_dat", rsp_dat, exp_dat);
        chk_eq("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk_eq("timeout_cnt", {24'b0, timeout_cnt}, exp_tcnt);
        chk_eq("resp_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk_eq("resp_busy", {31'b0, busy}, 32'd1);
        chk_eq("adr_held", wbm_adr_o, adr);

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            wbm_ack_i = 1'($urandom);
            tick();
            chk_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk_eq("hold_dat", rsp_dat, exp_dat);
            chk_eq("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk_eq("hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
            chk_eq("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        end
        wbm_ack_i = 1'b0;

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_eq("done_valid", {31'b0, rsp_valid}, 32'd0);
        chk_eq("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk_eq("done_busy", {31'b0, busy}, 32'd0);
        chk_eq("done_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int r;
        int w;

        repeat (3) @(negedge wb_clk_i);
        chk_eq("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk_eq("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk_eq("rst_adr", wbm_adr_o, 32'd0);
        chk_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk_eq("rst_rsp_dat", rsp_dat, 32'd0);
        chk_eq("rst_tcnt", {24'b0, timeout_cnt}, 32'd0);
        chk_eq("rst_busy", {31'b0, busy}, 32'd0);
        wb_rst_i = 1'b0;
        tick();
        chk_eq("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        wbm_ack_i = 1'b1;
        repeat (3) begin
            tick();
            chk_eq("idle_ack_ready", {31'b0, cmd_ready}, 32'd1);
            chk_eq("idle_ack_valid", {31'b0, rsp_valid}, 32'd0);
            chk_eq("idle_ack_busy", {31'b0, busy}, 32'd0);
        end
        wbm_ack_i = 1'b0;

        run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 3, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, -1, 32'h0, 0);
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, TO - 1, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 10);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 4);
            else if (r < 8) w = $urandom_range(5, 20);
            else            w = -1;
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), w, $urandom,
                    $urandom_range(0, 3));
        end

        for (int i = 0; i < 300; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), -1, 32'h0, 0);
        end
        chk_eq("tcnt_saturated", {24'b0, timeout_cnt}, 32'd255);

        // Reset during the 2nd STB cycle must kill the transfer silently.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0040;
        tick();
        cmd_valid = 1'b0;
        chk_eq("mid_stb1", {31'b0, wbm_stb_o}, 32'd1);
        tick();
        chk_eq("mid_stb2", {31'b0, wbm_stb_o}, 32'd1);
        wb_rst_i = 1'b1;
        tick();
        chk_eq("mid_rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk_eq("mid_rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk_eq("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        wb_rst_i = 1'b0;
        exp_tcnt = 0;
        repeat (5) begin
            tick();
            chk_eq("post_mid_valid", {31'b0, rsp_valid}, 32'd0);
            chk_eq("post_mid_ready", {31'b0, cmd_ready}, 32'd1);
            chk_eq("post_mid_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        end
        chk_eq("post_mid_tcnt", {24'b0, timeout_cnt}, 32'd0);
        run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-transfer initiator, the master-side counterpart of the user-project Wishbone slave port. Accepts one command at a time on a valid/ready interface and runs one Wishbone read or write cycle per command. Returns read data or a timeout error on a valid/ready response interface. Used by on-chip test sequencers and GPIO/LA-driven debug bridges to drive Wishbone slaves inside the user area.

Parameters:
TIMEOUT, 255, max cycles STB may stay high without ACK before abort; 0 disables the timeout.
CNT_W, 8, width of the saturating timeout-event counter.

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&ready
cmd_we  input  1  1=write, 0=read
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
cmd_sel  input  4  byte lane select
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&ready
rsp_dat  output  32  read data; 0 for writes and errors
rsp_err  output  1  1=transfer aborted by timeout
wbm_cyc_o  output  1  Wishbone CYC
wbm_stb_o  output  1  Wishbone STB
wbm_we_o  output  1  Wishbone WE
wbm_sel_o  output  4  Wishbone SEL
wbm_adr_o  output  32  Wishbone ADR
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone ACK
busy  output  1  high in BUS or RESP state
timeout_cnt  output  CNT_W  count of timeouts, saturating

Behaviour:
- Single clock domain. Reset is synchronous and active-high on wb_clk_i/wb_rst_i. No asynchronous reset anywhere.
- Reset values: state IDLE, all wbm_* outputs 0, rsp_valid 0, rsp_dat 0, rsp_err 0, timeout_cnt 0, busy 0. cmd_ready reads 1 in the cycle after reset deasserts.
- All outputs are registered, except cmd_ready = (state==IDLE).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear the wait counter, go to BUS. Latency: handshake at edge N puts CYC/STB high in cycle N+1.
  - BUS: hold all wbm_* outputs stable. If wbm_ack_i is high, capture rsp_dat (wbm_dat_i for reads, 0 for writes), set rsp_err=0, drop cyc/stb, set rsp_valid=1, go to RESP. Otherwise increment the wait counter. When the counter reaches TIMEOUT-1 with no ACK (and TIMEOUT!=0), drop cyc/stb, set rsp_dat=0, rsp_err=1, rsp_valid=1, increment timeout_cnt (saturating at all-ones), go to RESP. STB is therefore high for at most TIMEOUT cycles.
  - RESP: rsp_valid held with stable data until rsp_ready. On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
- ACK and timeout expiry in the same cycle: ACK wins, no error, counter unchanged.
- ACK while in IDLE or RESP is ignored, with no state change.
- No pipelining: one outstanding transfer. Minimum command-to-command spacing is 3 cycles (zero-wait ACK, rsp_ready held high).
- wbm_we/sel/adr/dat_o keep their last values after a cycle ends. Only cyc/stb return to 0.
- Reset mid-transfer: cyc/stb drop at the reset edge. Any pending response is discarded, with no rsp_valid pulse.
- Wait counter width is $clog2(TIMEOUT+1). Compare on equality, with no wrap-around.

Decomposition:
- Package wb_master_pkg: state enum (IDLE, BUS, RESP), WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- One sub-module, wb_timeout_ctr: clear/enable inputs and an expired output, parameterised by TIMEOUT. It also handles the TIMEOUT=0 disable case.

Test Plan:
- Read with zero-wait slave: cmd adr=0x3000_0004, we=0. Slave ACKs in the first STB cycle with 0xDEAD_BEEF. Expect CYC/STB high exactly 1 cycle, rsp_valid the next cycle, rsp_dat=0xDEAD_BEEF, rsp_err=0.
- Write with 3 wait states: cmd we=1, dat=0x1234_5678, sel=0xF. Expect STB high 4 cycles with ADR/DAT/SEL stable, then rsp_dat=0, rsp_err=0.
- Timeout with TIMEOUT=16 and slave never ACKs: expect STB high exactly 16 cycles, rsp_err=1, timeout_cnt=1. Repeat 300 times: timeout_cnt saturates at 255.
- ACK and expiry coincide: ACK on the 16th STB cycle with TIMEOUT=16. Expect rsp_err=0, correct data, timeout_cnt unchanged.
- Response backpressure: hold rsp_ready=0 for 10 cycles. Expect rsp_valid/rsp_dat stable, cmd_ready=0, no new CYC. Release: IDLE one cycle later.
- Reset mid-transfer: assert wb_rst_i during the 2nd STB cycle. Expect CYC/STB=0 at the next edge, rsp_valid never asserted, cmd_ready=1 after reset release.
